// File: rtl/lane_block_engine.sv
`default_nettype none
// ============================================================================
//  Module   : lane_block_engine
//  Brief    : One piano lane holding up to SLOTS falling tiles. Spawns tiles
//             on beat advances, moves live tiles down each unpaused tick,
//             judges key presses against a hit window and reports
//             hit / miss / bad-press / overflow pulses.
//  Revision : 1.0 - initial multi-slot release
// ============================================================================
module lane_block_engine #(
    parameter int H_W      = 10,
    parameter int SLOTS    = 4,
    parameter int SPAWN_Y  = 120,
    parameter int BOTTOM_Y = 720,
    parameter int STEP     = 1,
    parameter int HIT_LO   = 600,
    parameter int HIT_HI   = 680
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic                   pause,
    input  logic [6:0]             beat_cnt,
    input  logic                   spawn,
    input  logic                   key,
    output logic [SLOTS*H_W-1:0]   block_h,
    output logic [SLOTS-1:0]       block_vld,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic                   bad_pulse,
    output logic                   overflow
);

    localparam logic [H_W-1:0] c_SPAWN_Y   = H_W'(SPAWN_Y);
    localparam logic [H_W-1:0] c_BOTTOM_Y  = H_W'(BOTTOM_Y);
    localparam logic [H_W-1:0] c_STEP      = H_W'(STEP);
    localparam logic [H_W-1:0] c_HIT_LO    = H_W'(HIT_LO);
    localparam logic [H_W-1:0] c_HIT_HI    = H_W'(HIT_HI);
    // A tile at or beyond this height would reach BOTTOM_Y on its next move;
    // comparing against it avoids ever forming a sum that could wrap.
    localparam logic [H_W-1:0] c_RETIRE_TH = H_W'(BOTTOM_Y - STEP);

    logic [H_W-1:0]   r_h [SLOTS];
    logic [SLOTS-1:0] r_vld;
    logic [6:0]       r_pre_beat;
    logic             r_key_q;
    logic             r_hit;
    logic             r_miss;
    logic             r_bad;
    logic             r_ovf;

    logic             w_beat_add;
    logic             w_key_edge;
    logic             w_spawn_evt;
    logic             w_judge;
    logic [SLOTS-1:0] w_free_oh;
    logic             w_free_any;
    logic [SLOTS-1:0] w_hit_oh;
    logic             w_hit_any;
    logic [H_W-1:0]   w_best_h;
    logic [H_W-1:0]   w_h_nxt [SLOTS];
    logic [SLOTS-1:0] w_vld_nxt;
    logic             w_retire_any;

    assign w_beat_add  = (beat_cnt != r_pre_beat);
    assign w_key_edge  = key && !r_key_q;
    assign w_spawn_evt = w_beat_add && spawn && !pause;
    assign w_judge     = w_key_edge && !pause;

    // Pick the lowest free slot and the lowest-index tallest in-window tile.
    always_comb begin
        w_free_oh  = '0;
        w_free_any = 1'b0;
        w_hit_oh   = '0;
        w_hit_any  = 1'b0;
        w_best_h   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!r_vld[i] && !w_free_any) begin
                w_free_oh[i] = 1'b1;
                w_free_any   = 1'b1;
            end
            // Strict '>' keeps the earlier (lower-index) slot on a tie.
            if (r_vld[i] && (r_h[i] >= c_HIT_LO) && (r_h[i] <= c_HIT_HI) &&
                (!w_hit_any || (r_h[i] > w_best_h))) begin
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
                w_hit_any   = 1'b1;
                w_best_h    = r_h[i];
            end
        end
    end

    // Per-slot next state: hit removal beats motion; free slots may take a spawn.
    always_comb begin
        w_retire_any = 1'b0;
        w_vld_nxt    = r_vld;
        for (int i = 0; i < SLOTS; i++) begin
            w_h_nxt[i] = r_h[i];
            if (!pause) begin
                if (w_judge && w_hit_oh[i]) begin
                    w_vld_nxt[i] = 1'b0;
                    w_h_nxt[i]   = c_BOTTOM_Y;
                end else if (r_vld[i]) begin
                    if (r_h[i] >= c_RETIRE_TH) begin
                        w_vld_nxt[i] = 1'b0;
                        w_h_nxt[i]   = c_BOTTOM_Y;
                        w_retire_any = 1'b1;
                    end else begin
                        w_h_nxt[i] = r_h[i] + c_STEP;
                    end
                end else if (w_spawn_evt && w_free_oh[i]) begin
                    w_vld_nxt[i] = 1'b1;
                    w_h_nxt[i]   = c_SPAWN_Y;
                end
            end
        end
    end

    // Lane state and registered event pulses; restart acts like reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld      <= '0;
            r_pre_beat <= '0;
            r_key_q    <= 1'b0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_bad      <= 1'b0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_h[i] <= c_BOTTOM_Y;
            end
        end else if (restart) begin
            r_vld      <= '0;
            r_pre_beat <= '0;
            r_key_q    <= 1'b0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_bad      <= 1'b0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_h[i] <= c_BOTTOM_Y;
            end
        end else begin
            // Beat and key history track every cycle so paused events are dropped.
            r_pre_beat <= beat_cnt;
            r_key_q    <= key;
            r_vld      <= w_vld_nxt;
            r_hit      <= w_judge && w_hit_any;
            r_bad      <= w_judge && !w_hit_any;
            r_miss     <= w_retire_any;
            r_ovf      <= w_spawn_evt && !w_free_any;
            for (int i = 0; i < SLOTS; i++) begin
                r_h[i] <= w_h_nxt[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < SLOTS; g++) begin : g_out
            assign block_h[g*H_W +: H_W] = r_h[g];
        end
    endgenerate

    assign block_vld  = r_vld;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;
    assign bad_pulse  = r_bad;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lane_block_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_block_engine
//  Brief    : Directed bench for lane_block_engine with a pulse scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_block_engine;

    localparam int c_HW    = 10;
    localparam int c_SLOTS = 4;

    logic                      clk;
    logic                      rst;
    logic                      restart;
    logic                      pause;
    logic [6:0]                beat_cnt;
    logic                      spawn;
    logic                      key;
    logic [c_SLOTS*c_HW-1:0]   block_h;
    logic [c_SLOTS-1:0]        block_vld;
    logic                      hit_pulse;
    logic                      miss_pulse;
    logic                      bad_pulse;
    logic                      overflow;

    typedef struct {
        string      nm;
        logic [3:0] p;    // {hit, miss, bad, overflow}
        logic [3:0] vld;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    lane_block_engine dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .pause      (pause),
        .beat_cnt   (beat_cnt),
        .spawn      (spawn),
        .key        (key),
        .block_h    (block_h),
        .block_vld  (block_vld),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .bad_pulse  (bad_pulse),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int get_h(input int i);
        return int'(block_h[i*c_HW +: c_HW]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input string nm, input logic [3:0] p, input logic [3:0] v);
        exp_t e;
        e.nm  = nm;
        e.p   = p;
        e.vld = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_vld"}, int'(block_vld), 0);
        for (int i = 0; i < c_SLOTS; i++) chk({nm, "_h"}, get_h(i), 720);
    endtask

    // Scoreboard monitor: every pulse cycle must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] p;
        p = {hit_pulse, miss_pulse, bad_pulse, overflow};
        if (!rst && (p != 4'b0000)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got pulses %b vld %b expected no pulse", p, block_vld);
            end else begin
                e = exp_q.pop_front();
                if (p == e.p && block_vld == e.vld) n_pass++;
                else $display("FAIL %s: got pulses %b vld %b expected pulses %b vld %b",
                              e.nm, p, block_vld, e.p, e.vld);
            end
        end
    end

    initial begin
        rst = 1'b1; restart = 1'b0; pause = 1'b0;
        beat_cnt = 7'd0; spawn = 1'b0; key = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        chk_cleared("reset");
        chk("reset_pulses", int'({hit_pulse, miss_pulse, bad_pulse, overflow}), 0);

        // Single tile: spawn, fall, retire as a miss
        beat_cnt = 7'd2; step(1);
        beat_cnt = 7'd3; spawn = 1'b1; step(1);
        spawn = 1'b0;
        chk("spawn_vld", int'(block_vld), 4'b0001);
        chk("spawn_h", get_h(0), 120);
        step(599);
        chk("fall_vld", int'(block_vld), 4'b0001);
        chk("fall_h", get_h(0), 719);
        push("miss_single", 4'b0100, 4'b0000);
        step(1);
        chk("retire_vld", int'(block_vld), 0);
        chk("retire_h", get_h(0), 720);

        // Five spawns in a row: slots fill in order, fifth overflows
        spawn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            beat_cnt = beat_cnt + 7'd1;
            if (k == 4) push("overflow", 4'b0001, 4'b1111);
            step(1);
        end
        spawn = 1'b0;
        chk("fill_vld", int'(block_vld), 4'b1111);
        chk("fill_h0", get_h(0), 124);
        chk("fill_h1", get_h(1), 123);
        chk("fill_h2", get_h(2), 122);
        chk("fill_h3", get_h(3), 121);
        restart = 1'b1; step(1); restart = 1'b0;
        chk_cleared("restart4");
        step(1);

        // Hit at h=650, key held: exactly one judgement
        beat_cnt = beat_cnt + 7'd1; spawn = 1'b1; step(1); spawn = 1'b0;
        step(530);
        chk("pre_hit_h", get_h(0), 650);
        push("hit_650", 4'b1000, 4'b0000);
        key = 1'b1; step(1);
        chk("hit_vld", int'(block_vld), 0);
        chk("hit_h", get_h(0), 720);
        step(10);
        key = 1'b0; step(5);

        // Two tiles in window: the taller one is taken
        beat_cnt = beat_cnt + 7'd1; spawn = 1'b1; step(1); spawn = 1'b0;
        step(29);
        beat_cnt = beat_cnt + 7'd1; spawn = 1'b1; step(1); spawn = 1'b0;
        step(490);
        chk("pair_h0", get_h(0), 640);
        chk("pair_h1", get_h(1), 610);
        push("hit_tallest", 4'b1000, 4'b0010);
        key = 1'b1; step(1); key = 1'b0;
        chk("pair_vld", int'(block_vld), 4'b0010);
        chk("pair_h0_freed", get_h(0), 720);
        chk("pair_h1_moves", get_h(1), 611);
        push("miss_survivor", 4'b0100, 4'b0000);
        step(109);
        chk("survivor_gone", int'(block_vld), 0);

        // Key edge with tile outside window: bad press, tile continues
        beat_cnt = beat_cnt + 7'd1; spawn = 1'b1; step(1); spawn = 1'b0;
        step(380);
        chk("bad_pre_h", get_h(0), 500);
        push("bad_press", 4'b0010, 4'b0001);
        key = 1'b1; step(1);
        chk("bad_h", get_h(0), 501);
        chk("bad_vld", int'(block_vld), 4'b0001);
        key = 1'b0; step(1);

        // Pause: beats, spawns and key edges ignored, heights frozen
        pause = 1'b1; spawn = 1'b1;
        for (int k = 0; k < 50; k++) begin
            beat_cnt = beat_cnt + 7'd1;
            if (k == 10) key = 1'b1;
            if (k == 20) key = 1'b0;
            step(1);
        end
        chk("pause_h", get_h(0), 502);
        chk("pause_vld", int'(block_vld), 4'b0001);
        pause = 1'b0; spawn = 1'b0; step(1);
        chk("unpause_h", get_h(0), 503);
        chk("unpause_vld", int'(block_vld), 4'b0001);
        beat_cnt = 7'd127; step(1);
        beat_cnt = 7'd0; spawn = 1'b1; step(1); spawn = 1'b0;
        chk("wrap_vld", int'(block_vld), 4'b0011);
        chk("wrap_h1", get_h(1), 120);
        chk("wrap_h0", get_h(0), 505);

        // Restart with three live tiles
        beat_cnt = 7'd1; spawn = 1'b1; step(1); spawn = 1'b0;
        chk("three_vld", int'(block_vld), 4'b0111);
        restart = 1'b1; step(1); restart = 1'b0;
        chk_cleared("restart3");
        step(20);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
